// File: rtl/n163_sound_ram_port_pkg.sv
// Shared N163 constants: CPU address decode, channel-config location in sound RAM
// and the sound RAM address type.
package n163_sound_ram_port_pkg;

   typedef logic [6:0] sram_addr_t;

   // prg_ain[15:11] patterns: $F800-$FFFF address latch, $4800-$4FFF data window
   localparam logic [4:0] ADDR_LATCH_HI = 5'b11111;
   localparam logic [4:0] DATA_WIN_HI   = 5'b01001;

   localparam sram_addr_t CHCFG_ADDR = 7'h7F;
   localparam int         CHCNT_MSB  = 6;
   localparam int         CHCNT_LSB  = 4;

   function automatic logic addr_hit(input logic [15:0] ain, input logic [4:0] hi);
      return ain[15:11] == hi;
   endfunction

endpackage

// File: rtl/n163_sound_ram_port_dpram.sv
// Dual-port sound RAM: port A read/write (CPU), port B read-only (mixer).
// Reads are asynchronous; the caller registers the outputs.
module n163_sound_ram_port_dpram #(
   parameter int widthad_a = 7,
   parameter int width_a   = 8
)(
   input  logic                 clock,
   input  logic                 wren_a,
   input  logic [widthad_a-1:0] address_a,
   input  logic [width_a-1:0]   data_a,
   output logic [width_a-1:0]   q_a,
   input  logic [widthad_a-1:0] address_b,
   output logic [width_a-1:0]   q_b
);

   logic [width_a-1:0] r_mem [0:(2**widthad_a)-1];

   always_ff @(posedge clock) begin
      if (wren_a) r_mem[address_a] <= data_a;
   end

   assign q_a = r_mem[address_a];
   assign q_b = r_mem[address_b];

endmodule

// File: rtl/n163_sound_ram_port.sv
// N163 CPU port to the 128-byte sound RAM: $F800 pointer latch with auto-increment,
// $4800 data window read/write, mixer read port and shadowed channel count.
module n163_sound_ram_port
   import n163_sound_ram_port_pkg::*;
#(
   parameter int                ADDR_W     = 7,
   parameter logic [ADDR_W-1:0] CHCFG_ADDR = n163_sound_ram_port_pkg::CHCFG_ADDR
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              enable,
   input  logic [15:0]       prg_ain,
   input  logic              prg_read,
   input  logic              prg_write,
   input  logic [7:0]        prg_din,
   output logic [7:0]        prg_dout,
   output logic              prg_dout_oe,
   input  logic [ADDR_W-1:0] snd_addr,
   output logic [7:0]        snd_dout,
   output logic [2:0]        num_ch,
   input  logic              sound_disable
);

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;

   logic [ADDR_W-1:0] r_ram_ptr;
   logic              r_autoinc;
   logic [2:0]        r_num_ch;
   logic [7:0]        r_prg_dout;
   logic [7:0]        r_snd_dout;

   logic       w_cpu;
   logic       w_latch_wr;
   logic       w_data_wr;
   logic       w_data_rd;
   logic [7:0] w_q_a;
   logic [7:0] w_q_b;
   logic       w_unused;

   assign w_cpu      = ce & enable;
   assign w_latch_wr = w_cpu & prg_write & addr_hit(prg_ain, ADDR_LATCH_HI);
   assign w_data_wr  = w_cpu & prg_write & addr_hit(prg_ain, DATA_WIN_HI);
   assign w_data_rd  = w_cpu & prg_read  & addr_hit(prg_ain, DATA_WIN_HI);
   assign w_unused   = &{1'b0, prg_ain[10:0]};

   n163_sound_ram_port_dpram #(
      .widthad_a (ADDR_W),
      .width_a   (8)
   ) u_ram (
      .clock     (clk),
      .wren_a    (w_data_wr),
      .address_a (r_ram_ptr),
      .data_a    (prg_din),
      .q_a       (w_q_a),
      .address_b (snd_addr),
      .q_b       (w_q_b)
   );

   // Pointer/latch; the read increment lands after the pre-increment byte was returned
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ram_ptr <= '0;
         r_autoinc <= 1'b0;
         r_num_ch  <= 3'd0;
      end else begin
         if (w_latch_wr) begin
            r_autoinc <= prg_din[7];
            r_ram_ptr <= prg_din[ADDR_W-1:0];
         end else if ((w_data_wr || w_data_rd) && r_autoinc) begin
            r_ram_ptr <= r_ram_ptr + PTR_ONE;
         end
         if (w_data_wr && (r_ram_ptr == CHCFG_ADDR))
            r_num_ch <= prg_din[CHCNT_MSB:CHCNT_LSB];
      end
   end

   // Mixer sees the pre-write byte when it collides with a CPU write in the same clk
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prg_dout <= 8'h00;
         r_snd_dout <= 8'h00;
      end else begin
         r_prg_dout <= w_q_a;
         r_snd_dout <= sound_disable ? 8'h00 : w_q_b;
      end
   end

   assign prg_dout    = r_prg_dout;
   assign snd_dout    = r_snd_dout;
   assign num_ch      = r_num_ch;
   assign prg_dout_oe = enable & ~prg_write & addr_hit(prg_ain, DATA_WIN_HI);

endmodule

// File: tb/tb_n163_sound_ram_port.sv
// Bench for n163_sound_ram_port: directed scenarios plus random CPU/mixer traffic
// checked against an array-based model of the sound RAM port.
module tb_n163_sound_ram_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] prg_ain = 16'h0000;
   logic        prg_read = 1'b0;
   logic        prg_write = 1'b0;
   logic [7:0]  prg_din = 8'h00;
   logic [7:0]  prg_dout;
   logic        prg_dout_oe;
   logic [6:0]  snd_addr = 7'h00;
   logic [7:0]  snd_dout;
   logic [2:0]  num_ch;
   logic        sound_disable = 1'b0;

   always #5 clk = ~clk;

   n163_sound_ram_port dut (
      .clk           (clk),
      .reset         (reset),
      .ce            (ce),
      .enable        (enable),
      .prg_ain       (prg_ain),
      .prg_read      (prg_read),
      .prg_write     (prg_write),
      .prg_din       (prg_din),
      .prg_dout      (prg_dout),
      .prg_dout_oe   (prg_dout_oe),
      .snd_addr      (snd_addr),
      .snd_dout      (snd_dout),
      .num_ch        (num_ch),
      .sound_disable (sound_disable)
   );

   // Reference model
   logic [7:0] m_mem [0:127];
   logic [6:0] m_ptr = 7'd0;
   logic       m_ai = 1'b0;
   logic [2:0] m_nch = 3'd0;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      prg_ain = a; prg_din = d; prg_write = 1'b1; ce = 1'b1;
      #1 check("oe_on_write", 8'(prg_dout_oe), 8'h00);
      @(posedge clk); #1;
      ce = 1'b0; prg_write = 1'b0;
      if (enable) begin
         if (a[15:11] == 5'b11111) begin
            m_ai = d[7]; m_ptr = d[6:0];
         end else if (a[15:11] == 5'b01001) begin
            m_mem[m_ptr] = d;
            if (m_ptr == 7'h7F) m_nch = d[6:4];
            if (m_ai) m_ptr = m_ptr + 7'd1;
         end
      end
      check("num_ch", 8'(num_ch), 8'(m_nch));
      repeat (2) @(posedge clk);
   endtask

   task automatic cpu_rd(input logic [15:0] a);
      logic exp_oe;
      @(negedge clk);
      prg_ain = a; prg_read = 1'b1; ce = 1'b1;
      exp_oe = enable && (a[15:11] == 5'b01001);
      #1 check("oe_on_read", 8'(prg_dout_oe), 8'(exp_oe));
      if (exp_oe) check("rd_data", prg_dout, m_mem[m_ptr]);
      @(posedge clk); #1;
      ce = 1'b0; prg_read = 1'b0;
      if (exp_oe && m_ai) m_ptr = m_ptr + 7'd1;
      repeat (2) @(posedge clk);
   endtask

   task automatic mix_rd(input logic [6:0] a);
      @(negedge clk);
      snd_addr = a;
      @(posedge clk); #1;
      check("snd_dout", snd_dout, sound_disable ? 8'h00 : m_mem[a]);
   endtask

   initial begin
      int op;
      repeat (3) @(posedge clk);
      #1;
      check("rst_prg_dout", prg_dout, 8'h00);
      check("rst_snd_dout", snd_dout, 8'h00);
      check("rst_num_ch", 8'(num_ch), 8'h00);
      @(negedge clk) reset = 1'b0;

      // Fill RAM so every model byte is defined
      cpu_wr(16'hF800, 8'h80);
      for (int i = 0; i < 128; i++) cpu_wr(16'h4800, 8'($urandom_range(0, 255)));

      // Auto-increment write then readback
      cpu_wr(16'hF800, 8'h80);
      cpu_wr(16'h4800, 8'h11); cpu_wr(16'h4800, 8'h22); cpu_wr(16'h4800, 8'h33);
      cpu_wr(16'hF800, 8'h80);
      cpu_rd(16'h4800); cpu_rd(16'h4800); cpu_rd(16'h4800);
      check("ptr_is_3", 8'(m_ptr), 8'h03);
      cpu_rd(16'h4800);

      // Autoinc off
      cpu_wr(16'hF800, 8'h05);
      cpu_wr(16'h4800, 8'hAA);
      cpu_rd(16'h4FFF); cpu_rd(16'h4800);
      mix_rd(7'h05);
      check("aa_model", m_mem[5], 8'hAA);

      // Pointer wrap
      cpu_wr(16'hF800, 8'hFF);
      cpu_wr(16'h4800, 8'h01);
      cpu_wr(16'h4800, 8'h02);
      mix_rd(7'h7F); mix_rd(7'h00);

      // Channel count
      cpu_wr(16'hF800, 8'h7F);
      cpu_wr(16'h4800, 8'h70);
      check("num_ch_7", 8'(num_ch), 8'h07);
      cpu_rd(16'h4800);

      // CPU write and mixer read of the same byte in one clk
      cpu_wr(16'hF800, 8'h09);
      cpu_wr(16'h4800, 8'hC3);
      @(negedge clk);
      snd_addr = 7'h09; prg_ain = 16'h4800; prg_din = 8'h5A; prg_write = 1'b1; ce = 1'b1;
      @(posedge clk); #1;
      ce = 1'b0; prg_write = 1'b0;
      check("coll_old", snd_dout, 8'hC3);
      m_mem[9] = 8'h5A;
      @(posedge clk); #1;
      check("coll_new", snd_dout, 8'h5A);
      @(negedge clk) sound_disable = 1'b1;
      @(posedge clk); #1;
      check("snd_disabled", snd_dout, 8'h00);
      @(negedge clk) sound_disable = 1'b0;
      repeat (2) @(posedge clk);

      // Reset between auto-increment writes
      cpu_wr(16'hF800, 8'h90);
      cpu_wr(16'h4800, 8'hA1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_prg_dout", prg_dout, 8'h00);
      check("arst_snd_dout", snd_dout, 8'h00);
      check("arst_num_ch", 8'(num_ch), 8'h00);
      m_ptr = 7'd0; m_ai = 1'b0; m_nch = 3'd0;
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      cpu_rd(16'h4800); cpu_rd(16'h4800);
      cpu_wr(16'hF800, 8'h91);
      cpu_wr(16'h4800, 8'hA2);
      cpu_wr(16'hF800, 8'h10);
      cpu_rd(16'h4800); cpu_rd(16'h4800);
      check("a1_model", m_mem[16], 8'hA1);

      // Mapper not selected
      enable = 1'b0;
      cpu_wr(16'hF800, 8'hA0);
      cpu_wr(16'h4800, 8'hEE);
      cpu_rd(16'h4800);
      mix_rd(7'h10);
      enable = 1'b1;
      cpu_rd(16'h4800);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 9);
         case (op)
            0, 1:    cpu_wr(16'hF800 | 16'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)));
            2, 3, 4: cpu_wr(16'h4800 | 16'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)));
            5, 6:    cpu_rd(16'h4800 | 16'($urandom_range(0, 2047)));
            7: begin
               sound_disable = ($urandom_range(0, 3) == 0);
               mix_rd(7'($urandom_range(0, 127)));
            end
            8: enable = ($urandom_range(0, 3) != 0);
            default: begin
               cpu_wr(16'h6000 | 16'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
               cpu_rd(16'h5000 | 16'($urandom_range(0, 2047)));
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
